// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags. Commit writes
// retired values, issue records producer ROB entries, lookups resolve operands.
module reg_file #(
  parameter int ROB_BIT = 3,
  parameter int REG_NUM = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_up,
  input  logic               issue_valid,
  input  logic [4:0]         issue_reg_id,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic               commit_valid,
  input  logic [4:0]         commit_reg_id,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [31:0]        commit_value,
  input  logic [4:0]         rs1_id,
  output logic               rs1_busy,
  output logic [ROB_BIT-1:0] rs1_rob_entry,
  output logic [31:0]        rs1_value,
  input  logic [4:0]         rs2_id,
  output logic               rs2_busy,
  output logic [ROB_BIT-1:0] rs2_rob_entry,
  output logic [31:0]        rs2_value,
  output logic [ROB_BIT-1:0] get_rob_entry1,
  input  logic               rob_ready1,
  input  logic [31:0]        rob_value1,
  output logic [ROB_BIT-1:0] get_rob_entry2,
  input  logic               rob_ready2,
  input  logic [31:0]        rob_value2
);

  typedef struct packed {
    logic               busy;
    logic [ROB_BIT-1:0] entry;
    logic [31:0]        value;
  } lookup_t;

  logic [31:0]        regs [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic [ROB_BIT-1:0] tag  [REG_NUM];
  lookup_t            lk1, lk2;

  // Issue is applied after commit so a same-register issue overrides busy/tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
      busy <= '0;
    end else if (rdy_in) begin
      if (commit_valid && commit_reg_id != 5'd0) begin
        regs[commit_reg_id] <= commit_value;
        if (busy[commit_reg_id] && tag[commit_reg_id] == commit_rob_entry)
          busy[commit_reg_id] <= 1'b0;
      end
      if (clear_up) begin
        busy <= '0;
        for (int i = 0; i < REG_NUM; i++) tag[i] <= '0;
      end else if (issue_valid && issue_reg_id != 5'd0) begin
        busy[issue_reg_id] <= 1'b1;
        tag[issue_reg_id]  <= issue_rob_entry;
      end
    end
  end

  function automatic lookup_t lookup(
    input logic [4:0]         id,
    input logic               r_busy,
    input logic [ROB_BIT-1:0] r_tag,
    input logic [31:0]        r_val,
    input logic               c_valid,
    input logic [4:0]         c_id,
    input logic [ROB_BIT-1:0] c_entry,
    input logic [31:0]        c_val,
    input logic               rob_ready,
    input logic [31:0]        rob_value
  );
    lookup_t r;
    r = '0;
    if (id == 5'd0)                                      r.value = '0;
    else if (!r_busy)                                    r.value = r_val;
    else if (c_valid && c_id == id && c_entry == r_tag)  r.value = c_val;
    else if (rob_ready)                                  r.value = rob_value;
    else begin
      r.busy  = 1'b1;
      r.entry = r_tag;
    end
    return r;
  endfunction

  always_comb begin
    lk1 = lookup(rs1_id, busy[rs1_id], tag[rs1_id], regs[rs1_id], commit_valid,
                 commit_reg_id, commit_rob_entry, commit_value, rob_ready1, rob_value1);
    lk2 = lookup(rs2_id, busy[rs2_id], tag[rs2_id], regs[rs2_id], commit_valid,
                 commit_reg_id, commit_rob_entry, commit_value, rob_ready2, rob_value2);
  end

  assign rs1_busy       = lk1.busy;
  assign rs1_rob_entry  = lk1.entry;
  assign rs1_value      = lk1.value;
  assign rs2_busy       = lk2.busy;
  assign rs2_rob_entry  = lk2.entry;
  assign rs2_value      = lk2.value;
  assign get_rob_entry1 = tag[rs1_id];
  assign get_rob_entry2 = tag[rs2_id];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_reg_file;
  localparam int RB = 3;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear_up;
  logic          issue_valid, commit_valid;
  logic [4:0]    issue_reg_id, commit_reg_id, rs1_id, rs2_id;
  logic [RB-1:0] issue_rob_entry, commit_rob_entry;
  logic [31:0]   commit_value, rob_value1, rob_value2, rs1_value, rs2_value;
  logic          rob_ready1, rob_ready2, rs1_busy, rs2_busy;
  logic [RB-1:0] rs1_rob_entry, rs2_rob_entry, get_rob_entry1, get_rob_entry2;

  always #5 clk_in = ~clk_in;

  reg_file #(.ROB_BIT(RB), .REG_NUM(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_up(clear_up),
    .issue_valid(issue_valid), .issue_reg_id(issue_reg_id), .issue_rob_entry(issue_rob_entry),
    .commit_valid(commit_valid), .commit_reg_id(commit_reg_id),
    .commit_rob_entry(commit_rob_entry), .commit_value(commit_value),
    .rs1_id(rs1_id), .rs1_busy(rs1_busy), .rs1_rob_entry(rs1_rob_entry), .rs1_value(rs1_value),
    .rs2_id(rs2_id), .rs2_busy(rs2_busy), .rs2_rob_entry(rs2_rob_entry), .rs2_value(rs2_value),
    .get_rob_entry1(get_rob_entry1), .rob_ready1(rob_ready1), .rob_value1(rob_value1),
    .get_rob_entry2(get_rob_entry2), .rob_ready2(rob_ready2), .rob_value2(rob_value2)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]   m_regs [32];
  logic          m_busy [32];
  logic [RB-1:0] m_tag  [32];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic void ref_lookup(input logic [4:0] id, input logic rr, input logic [31:0] rv,
                                     output logic b, output logic [RB-1:0] e, output logic [31:0] v);
    b = 1'b0; e = '0; v = '0;
    if (id != 5'd0) begin
      if (!m_busy[id]) v = m_regs[id];
      else if (commit_valid && commit_reg_id == id && commit_rob_entry == m_tag[id]) v = commit_value;
      else if (rr) v = rv;
      else begin b = 1'b1; e = m_tag[id]; end
    end
  endfunction

  task automatic check_ports();
    logic b; logic [RB-1:0] e; logic [31:0] v;
    ref_lookup(rs1_id, rob_ready1, rob_value1, b, e, v);
    chk("rs1_busy", rs1_busy, b);
    chk("rs1_rob_entry", rs1_rob_entry, e);
    chk("rs1_value", rs1_value, v);
    chk("get_rob_entry1", get_rob_entry1, m_tag[rs1_id]);
    ref_lookup(rs2_id, rob_ready2, rob_value2, b, e, v);
    chk("rs2_busy", rs2_busy, b);
    chk("rs2_rob_entry", rs2_rob_entry, e);
    chk("rs2_value", rs2_value, v);
    chk("get_rob_entry2", get_rob_entry2, m_tag[rs2_id]);
  endtask

  task automatic model_step();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
    end else if (rdy_in) begin
      if (commit_valid && commit_reg_id != 0) begin
        m_regs[commit_reg_id] = commit_value;
        if (m_busy[commit_reg_id] && m_tag[commit_reg_id] == commit_rob_entry)
          m_busy[commit_reg_id] = 1'b0;
      end
      if (clear_up) begin
        for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
      end else if (issue_valid && issue_reg_id != 0) begin
        m_busy[issue_reg_id] = 1'b1;
        m_tag[issue_reg_id]  = issue_rob_entry;
      end
    end
  endtask

  task automatic tick(input bit do_chk);
    @(negedge clk_in);
    if (do_chk) check_ports();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; clear_up = 0;
    issue_valid = 0; issue_reg_id = 0; issue_rob_entry = 0;
    commit_valid = 0; commit_reg_id = 0; commit_rob_entry = 0; commit_value = 0;
    rob_ready1 = 0; rob_value1 = 0; rob_ready2 = 0; rob_value2 = 0;
  endtask

  task automatic issue(input logic [4:0] id, input logic [RB-1:0] e);
    idle(); issue_valid = 1; issue_reg_id = id; issue_rob_entry = e; tick(1);
  endtask

  // Walk every register on both ports with state frozen (rdy_in low).
  task automatic probe();
    idle(); rdy_in = 0;
    for (int i = 0; i < 32; i++) begin
      rs1_id = 5'(i); rs2_id = 5'(31 - i); #1;
      check_ports();
    end
    idle();
  endtask

  initial begin
    idle(); rs1_id = 0; rs2_id = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
    rst_in = 1; tick(0); tick(0);
    idle();

    // 1: reset state and x0 immunity
    rs1_id = 5; #1;
    chk("t1_rs1_busy", rs1_busy, 0); chk("t1_rs1_value", rs1_value, 0);
    probe();
    issue_valid = 1; issue_reg_id = 0; issue_rob_entry = 3;
    commit_valid = 1; commit_reg_id = 0; commit_rob_entry = 0; commit_value = 32'hDEAD;
    tick(1); idle(); rs1_id = 0; #1;
    chk("t1_x0_value", rs1_value, 0); chk("t1_x0_busy", rs1_busy, 0);
    chk("t1_x0_entry", rs1_rob_entry, 0); chk("t1_x0_get", get_rob_entry1, 0);

    // 2: issue then ROB-ready forwarding then commit
    issue(3, 2); rs1_id = 3; #1;
    chk("t2_busy", rs1_busy, 1); chk("t2_entry", rs1_rob_entry, 2); chk("t2_get", get_rob_entry1, 2);
    rob_ready1 = 1; rob_value1 = 32'h55; #1;
    chk("t2_fwd_busy", rs1_busy, 0); chk("t2_fwd_value", rs1_value, 32'h55);
    tick(1);
    idle(); commit_valid = 1; commit_reg_id = 3; commit_rob_entry = 2; commit_value = 32'h55; tick(1);
    idle(); #1;
    chk("t2_commit_busy", rs1_busy, 0); chk("t2_commit_value", rs1_value, 32'h55);

    // 3: older commit leaves younger tag in place
    issue(4, 1); issue(4, 5);
    idle(); commit_valid = 1; commit_reg_id = 4; commit_rob_entry = 1; commit_value = 32'h11; tick(1);
    idle(); rs2_id = 4; #1;
    chk("t3_busy", rs2_busy, 1); chk("t3_entry", rs2_rob_entry, 5);

    // 4: same-cycle commit and issue on x6
    issue(6, 0);
    commit_valid = 1; commit_reg_id = 6; commit_rob_entry = 0; commit_value = 32'h77;
    issue_valid = 1; issue_reg_id = 6; issue_rob_entry = 3; rs1_id = 6; #1;
    chk("t4_bypass_busy", rs1_busy, 0); chk("t4_bypass_value", rs1_value, 32'h77);
    tick(1); idle(); #1;
    chk("t4_busy", rs1_busy, 1); chk("t4_entry", rs1_rob_entry, 3);

    // 5: flush with concurrent commit and ignored issue
    issue(7, 1); issue(8, 2); issue(9, 4);
    clear_up = 1; issue_valid = 1; issue_reg_id = 10; issue_rob_entry = 6;
    commit_valid = 1; commit_reg_id = 9; commit_rob_entry = 4; commit_value = 32'h99;
    tick(1);
    idle(); rs1_id = 9; rs2_id = 10; #1;
    chk("t5_x9_value", rs1_value, 32'h99); chk("t5_x10_busy", rs2_busy, 0);
    probe();

    // 6: stall holds state, reset overrides stall
    issue(11, 7);
    for (int i = 0; i < 3; i++) begin
      rdy_in = 0; clear_up = 1; issue_valid = 1; issue_reg_id = 12; issue_rob_entry = 1;
      commit_valid = 1; commit_reg_id = 11; commit_rob_entry = 7; commit_value = 32'h1234;
      rs1_id = 11; tick(1);
    end
    idle(); rs1_id = 11; #1;
    chk("t6_hold_busy", rs1_busy, 1); chk("t6_hold_entry", rs1_rob_entry, 7);
    rdy_in = 0; rst_in = 1; tick(0);
    idle(); rs1_id = 3; rs2_id = 11; #1;
    chk("t6_rst_value", rs1_value, 0); chk("t6_rst_busy", rs2_busy, 0);
    probe();

    // Randomized traffic concentrated on a few registers
    for (int n = 0; n < 400; n++) begin
      rst_in           = ($urandom_range(0, 59) == 0);
      rdy_in           = ($urandom_range(0, 4) != 0);
      clear_up         = ($urandom_range(0, 19) == 0);
      issue_valid      = $urandom_range(0, 1);
      issue_reg_id     = 5'($urandom_range(0, 7));
      issue_rob_entry  = RB'($urandom);
      commit_valid     = $urandom_range(0, 1);
      commit_reg_id    = 5'($urandom_range(0, 7));
      commit_rob_entry = $urandom_range(0, 1) ? m_tag[commit_reg_id] : RB'($urandom);
      commit_value     = $urandom;
      rs1_id           = 5'($urandom_range(0, 7));
      rs2_id           = 5'($urandom_range(0, 7));
      rob_ready1       = ($urandom_range(0, 2) == 0);
      rob_value1       = $urandom;
      rob_ready2       = ($urandom_range(0, 2) == 0);
      rob_value2       = $urandom;
      tick(1);
      if (n % 100 == 99) probe();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags, directly downstream of the reorder buffer.
- Consumes the ROB's issue stream, which records which ROB entry will produce each rd.
- Consumes the ROB's commit stream, which writes retired values and clears tags.
- Serves two operand-lookup ports to the decoder/dispatch stage and resolves in-flight operands through the ROB's ready/value lookup ports. Flushes all tags on mispredict (clear_up).

Parameters:
ROB_BIT, 3, width of a ROB entry index (ROB holds 2^ROB_BIT entries)
REG_NUM, 32, number of architectural registers (x0 hardwired zero)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  pause when low; all state held
clear_up  input  1  mispredict flush from ROB
issue_valid  input  1  ROB allocating an entry that writes a register
issue_reg_id  input  5  destination register of the issued entry
issue_rob_entry  input  ROB_BIT  ROB entry allocated
commit_valid  input  1  ROB retiring a register-writing entry
commit_reg_id  input  5  destination register being retired
commit_rob_entry  input  ROB_BIT  ROB entry being retired
commit_value  input  32  retired result
rs1_id  input  5  operand-1 register index from decoder
rs1_busy  output  1  operand 1 still pending
rs1_rob_entry  output  ROB_BIT  producer tag when rs1_busy=1, else 0
rs1_value  output  32  operand-1 value when rs1_busy=0, else 0
rs2_id, rs2_busy, rs2_rob_entry, rs2_value  (same as rs1_*, second port)
get_rob_entry1  output  ROB_BIT  tag of rs1_id sent to ROB lookup
rob_ready1  input  1  ROB entry get_rob_entry1 has a value (including same-cycle broadcast)
rob_value1  input  32  that value
get_rob_entry2, rob_ready2, rob_value2  (same, port 2)

Behaviour:
- State: regs[0..31] (32b), busy[0..31] (1b), tag[0..31] (ROB_BIT b).
- Reset (rst_in=1 at posedge): all regs, busy and tag set to 0, irrespective of rdy_in or other inputs. All outputs combinational; after reset every rsN_value=0, rsN_busy=0, rsN_rob_entry=0.
- rdy_in=0 and rst_in=0: no state change.
- Commit (rdy_in=1, commit_valid=1, commit_reg_id!=0):
  - regs[rd] <= commit_value.
  - If busy[rd] and tag[rd]==commit_rob_entry, busy[rd] <= 0.
  - If the tag differs (a younger writer exists), busy and tag are unchanged.
- Issue (rdy_in=1, issue_valid=1, issue_reg_id!=0, clear_up=0): busy[rd] <= 1, tag[rd] <= issue_rob_entry.
- Issue vs commit on the same rd in the same cycle: issue wins for busy and tag; the commit value is still written to regs.
- clear_up=1 with rdy_in=1:
  - All busy and tag cleared to 0; issue ignored.
  - A commit in the same cycle still writes regs.
- x0: never written, never tagged; rsN_id=0 always gives busy=0, value=0, rob_entry=0.
- Lookup, per port, combinational, evaluated against pre-clock-edge state. A same-cycle issue to the same register is not visible, so "add x1,x1,x1" reads the previous producer. Priority:
  1. id==0 -> value 0, not busy.
  2. !busy[id] -> value regs[id], not busy.
  3. commit_valid && commit_reg_id==id && commit_rob_entry==tag[id] -> value commit_value, not busy.
  4. rob_readyN -> value rob_valueN, not busy.
  5. Otherwise busy=1, rob_entry=tag[id], value 0.
- get_rob_entryN = tag[rsN_id], always driven (0 when id=0).
- Tag wrap-around: tags compare by full ROB_BIT index only. The ROB guarantees that no live entry index is reused before retirement.
- Lookups depend only on state and inputs; they are unaffected by rdy_in.

Test Plan:
1. Reset, then rs1_id=5 -> rs1_busy=0, rs1_value=0; attempt issue+commit to x0 with value 0xDEAD -> rs1_id=0 still returns 0, not busy.
2. Issue x3 entry 2; next cycle rs1_id=3, rob_ready1=0 -> busy=1, rob_entry=2, get_rob_entry1=2. Then rob_ready1=1, rob_value1=0x55 -> busy=0, value 0x55. Commit x3 entry 2 value 0x55 -> busy[3]=0, regs[3]=0x55.
3. Issue x4 entry 1, then issue x4 entry 5; commit x4 entry 1 value 0x11 -> regs[4]=0x11, rs2_id=4 still busy with tag 5.
4. Same cycle: commit x6 entry 0 value 0x77 and issue x6 entry 3 -> next cycle busy[6]=1, tag 3, regs[6]=0x77. Also in that cycle, a read of x6 returns 0x77 not busy via the commit bypass.
5. Tag x7, x8, x9; assert clear_up with commit x9 value 0x99 and issue x10 -> all busy=0, regs[9]=0x99, x10 not tagged.
6. Hold rdy_in=0 for 3 cycles with issue/commit/clear_up asserted -> state unchanged. Assert rst_in mid-sequence with rdy_in=0 -> all cleared next cycle.
